// File: rtl/cipher_char_sequencer.sv
// Sequences one ASCII character at a time through an external one-hot
// Caesar cipher: drive letter/shift one-hots, wait to settle, capture result.
module cipher_char_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_char,
    input  logic        dir_en,
    input  logic        key_load,
    input  logic [4:0]  key_shift,
    output logic [25:0] letter_oh,
    output logic [25:0] shift_oh,
    output logic        cap,
    output logic        en,
    input  logic [7:0]  cipher_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_char,
    output logic        key_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        OUT   = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  key_q, key_d;
    logic [7:0]  out_char_q, out_char_d;
    logic [25:0] letter_oh_q, letter_oh_d;
    logic        cap_q, cap_d;
    logic        en_q, en_d;
    logic        key_err_q, key_err_d;

    logic        is_lower;
    logic        is_upper;
    logic [4:0]  letter_idx;
    logic        key_legal;

    // 'a' and 'A' both have low five bits 5'd1, so case folding is free
    always_comb begin
        is_lower   = (in_char >= 8'h61) && (in_char <= 8'h7a);
        is_upper   = (in_char >= 8'h41) && (in_char <= 8'h5a);
        letter_idx = in_char[4:0] - 5'd1;
        key_legal  = (key_shift >= 5'd1) && (key_shift <= 5'd26);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        out_char_d  = out_char_q;
        letter_oh_d = letter_oh_q;
        cap_d       = cap_q;
        en_d        = en_q;
        key_err_d   = key_err_q;
        unique case (state_q)
            IDLE: begin
                if (key_load) begin
                    if (key_legal) begin
                        key_d = key_shift;
                    end else begin
                        key_err_d = 1'b1;
                    end
                end
                if (in_valid) begin
                    en_d = dir_en;
                    if (is_lower || is_upper) begin
                        state_d     = DRIVE;
                        cnt_d       = SETTLE;
                        letter_oh_d = 26'd1 << letter_idx;
                        cap_d       = is_upper;
                    end else begin
                        state_d    = OUT;
                        out_char_d = in_char;
                    end
                end
            end
            DRIVE: begin
                if (cnt_q == 4'd1) begin
                    out_char_d  = cipher_out;
                    letter_oh_d = '0;
                    cap_d       = 1'b0;
                    state_d     = OUT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            key_q       <= 5'd26;
            out_char_q  <= 8'h00;
            letter_oh_q <= '0;
            cap_q       <= 1'b0;
            en_q        <= 1'b0;
            key_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            out_char_q  <= out_char_d;
            letter_oh_q <= letter_oh_d;
            cap_q       <= cap_d;
            en_q        <= en_d;
            key_err_q   <= key_err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign out_char  = out_char_q;
    assign letter_oh = letter_oh_q;
    assign cap       = cap_q;
    assign en        = en_q;
    assign key_err   = key_err_q;
    assign shift_oh  = 26'd1 << (key_q - 5'd1);

endmodule

// File: tb/tb_cipher_char_sequencer.sv
// Directed bench for cipher_char_sequencer with a one-hot Caesar cipher model
// and a per-cycle compare against expectations derived from character rules.
module tb_cipher_char_sequencer;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_char;
    logic        dir_en;
    logic        key_load;
    logic [4:0]  key_shift;
    logic [25:0] letter_oh;
    logic [25:0] shift_oh;
    logic        cap;
    logic        en;
    logic [7:0]  cipher_out;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_char;
    logic        key_err;

    cipher_char_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_char    (in_char),
        .dir_en     (dir_en),
        .key_load   (key_load),
        .key_shift  (key_shift),
        .letter_oh  (letter_oh),
        .shift_oh   (shift_oh),
        .cap        (cap),
        .en         (en),
        .cipher_out (cipher_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_char   (out_char),
        .key_err    (key_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // External cipher: shift the one-hot letter by the one-hot key
    always_comb begin
        int li;
        int sh;
        int r;
        li = -1;
        sh = 0;
        r = 0;
        for (int i = 0; i < 26; i++) begin
            if (letter_oh[i]) li = i;
            if (shift_oh[i]) sh = i + 1;
        end
        if (li < 0) begin
            cipher_out = 8'h3f;
        end else begin
            r = en ? (li - sh + 52) % 26 : (li + sh) % 26;
            cipher_out = (cap ? 8'h41 : 8'h61) + 8'(r);
        end
    end

    function automatic bit is_letter(input logic [7:0] c);
        return (c >= 8'h41 && c <= 8'h5a) || (c >= 8'h61 && c <= 8'h7a);
    endfunction

    function automatic logic [7:0] caesar(input logic [7:0] c, input int k,
                                          input bit d);
        int base;
        int idx;
        int r;
        base = (c <= 8'h5a) ? 65 : 97;
        idx = int'(c) - base;
        r = d ? (idx - k + 52) % 26 : (idx + k) % 26;
        return 8'(base + r);
    endfunction

    // Expectations maintained by the stimulus, checked every cycle
    logic [25:0] e_loh;
    logic        e_cap;
    logic        e_en;
    logic        e_en_chk;
    logic        e_in_ready;
    logic        e_out_valid;
    logic [7:0]  e_out;
    logic        e_out_chk;
    logic        e_err;
    int          e_key;
    bit          mon_on = 1'b0;

    always @(negedge clk) begin
        if (mon_on) begin
            chk("in_ready", in_ready, e_in_ready);
            chk("out_valid", out_valid, e_out_valid);
            chk("letter_oh", letter_oh, e_loh);
            chk("cap", cap, e_cap);
            chk("shift_oh", shift_oh, 26'd1 << (e_key - 1));
            chk("key_err", key_err, e_err);
            if (e_out_chk) chk("out_char", out_char, e_out);
            if (e_en_chk) chk("en", en, e_en);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_reset_exp;
        e_loh = '0;
        e_cap = 1'b0;
        e_en = 1'b0;
        e_en_chk = 1'b1;
        e_in_ready = 1'b1;
        e_out_valid = 1'b0;
        e_out = 8'h00;
        e_out_chk = 1'b1;
        e_err = 1'b0;
        e_key = 26;
    endtask

    task automatic load(input logic [4:0] k);
        key_load = 1'b1;
        key_shift = k;
        step;
        key_load = 1'b0;
        if (k >= 5'd1 && k <= 5'd26) e_key = int'(k);
        else e_err = 1'b1;
    endtask

    // Offer one character; optionally load a key in the same cycle and
    // poke key_load while busy, then hold the result for 'hold' cycles.
    task automatic send(input logic [7:0] c, input bit d, input int hold,
                        input int newkey, input bit poke,
                        output logic [7:0] got);
        bit lt;
        lt = is_letter(c);
        in_valid = 1'b1;
        in_char = c;
        dir_en = d;
        if (newkey > 0) begin
            key_load = 1'b1;
            key_shift = 5'(newkey);
        end
        e_out_chk = 1'b0;
        e_en_chk = 1'b0;
        step;
        in_valid = 1'b0;
        key_load = 1'b0;
        if (newkey > 0) e_key = newkey;
        e_in_ready = 1'b0;
        if (lt) begin
            e_loh = 26'd1 << (int'(c[4:0]) - 1);
            e_cap = (c <= 8'h5a);
            e_en = d;
            e_en_chk = 1'b1;
            for (int i = 0; i < S; i++) begin
                if (poke && i == 0) begin
                    key_load = 1'b1;
                    key_shift = 5'd0;
                end
                step;
                key_load = 1'b0;
            end
            e_loh = '0;
            e_cap = 1'b0;
            e_en_chk = 1'b0;
            e_out = caesar(c, e_key, d);
        end else begin
            e_out = c;
        end
        e_out_valid = 1'b1;
        e_out_chk = 1'b1;
        @(negedge clk);
        got = out_char;
        for (int i = 0; i < hold; i++) begin
            if (poke && i == 0) begin
                key_load = 1'b1;
                key_shift = 5'd3;
            end
            step;
            key_load = 1'b0;
        end
        if (hold == 0) step;
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        e_out_valid = 1'b0;
        e_in_ready = 1'b1;
        e_out_chk = 1'b0;
    endtask

    task automatic rst_mid(input logic [7:0] c, input bit in_out);
        in_valid = 1'b1;
        in_char = c;
        dir_en = 1'b0;
        e_out_chk = 1'b0;
        e_en_chk = 1'b0;
        step;
        in_valid = 1'b0;
        e_in_ready = 1'b0;
        e_loh = 26'd1 << (int'(c[4:0]) - 1);
        e_cap = (c <= 8'h5a);
        if (in_out) begin
            repeat (S) step;
            e_loh = '0;
            e_cap = 1'b0;
            e_out_valid = 1'b1;
            e_out = caesar(c, e_key, 1'b0);
            e_out_chk = 1'b1;
            step;
        end
        rst = 1'b1;
        step;
        rst = 1'b0;
        set_reset_exp;
        repeat (4) step;
    endtask

    logic [7:0] got;
    logic [7:0] chars [8];

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_char = 8'h00;
        dir_en = 1'b0;
        key_load = 1'b0;
        key_shift = 5'd0;
        out_ready = 1'b0;
        set_reset_exp;
        step;
        mon_on = 1'b1;
        step;
        rst = 1'b0;
        step;

        chk("pin_a6", caesar(8'h61, 6, 1'b0), 8'h67);
        chk("pin_Z26", caesar(8'h5a, 26, 1'b0), 8'h5a);
        chk("pin_Q8d", caesar(8'h51, 8, 1'b1), 8'h49);
        chk("pin_x3", caesar(8'h78, 3, 1'b0), 8'h61);

        load(5'd6);
        send(8'h61, 1'b0, 0, 0, 1'b0, got);
        chk("a_key6", got, 8'h67);

        load(5'd26);
        send(8'h5a, 1'b0, 2, 0, 1'b0, got);
        chk("Z_key26", got, 8'h5a);

        send(8'h20, 1'b0, 0, 0, 1'b0, got);
        chk("space", got, 8'h20);

        load(5'd0);
        load(5'd27);
        load(5'd31);
        load(5'd8);

        send(8'h51, 1'b1, 5, 0, 1'b1, got);
        chk("Q_dec8", got, 8'h49);

        send(8'h78, 1'b0, 1, 3, 1'b0, got);
        chk("x_samecyc_key3", got, 8'h61);

        chars[0] = 8'h40;
        chars[1] = 8'h5b;
        chars[2] = 8'h60;
        chars[3] = 8'h7b;
        chars[4] = 8'h41;
        chars[5] = 8'h7a;
        chars[6] = 8'h39;
        chars[7] = 8'h6d;
        for (int i = 0; i < 8; i++) begin
            send(chars[i], 1'(i), i % 3, 0, 1'b0, got);
        end

        load(5'd1);
        send(8'h7a, 1'b0, 0, 0, 1'b0, got);
        chk("z_wrap", got, 8'h61);

        rst_mid(8'h4d, 1'b0);
        rst_mid(8'h6b, 1'b1);

        send(8'h62, 1'b1, 0, 0, 1'b0, got);
        chk("b_after_rst", got, 8'h62);

        repeat (2) step;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cipher_char_sequencer.md
CIPHER_CHAR_SEQUENCER -- requirements
Module: cipher_char_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, giving the number of cycles the one-hot drive is held before cipher_out is sampled (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, meaning an input character is offered.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block accepts in_char this cycle.
REQ-006 The block SHALL have port in_char, input, 8, the ASCII input character.
REQ-007 The block SHALL have port dir_en, input, 1, the encrypt/decrypt mode, sampled with each accepted character.
REQ-008 The block SHALL have port key_load, input, 1, a one-cycle key-update strobe.
REQ-009 The block SHALL have port key_shift, input, 5, the binary shift value 1..26.
REQ-010 The block SHALL have port letter_oh, output, 26, the one-hot letter drive to the cipher (bit0='a' ... bit25='z').
REQ-011 The block SHALL have port shift_oh, output, 26, the one-hot shift drive to the cipher (bit0=shift 1 ... bit25=shift 26).
REQ-012 The block SHALL have port cap, output, 1, the cipher capital-letter select.
REQ-013 The block SHALL have port en, output, 1, the cipher mode select.
REQ-014 The block SHALL have port cipher_out, input, 8, the ASCII result returned by the cipher.
REQ-015 The block SHALL have port out_valid, output, 1, meaning out_char holds a result.
REQ-016 The block SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-017 The block SHALL have port out_char, output, 8, the result character.
REQ-018 The block SHALL have port key_err, output, 1, a sticky flag set on an illegal key load.

Function
REQ-019 The FSM SHALL have states IDLE, DRIVE and OUT; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in OUT.
REQ-020 In IDLE, in_valid=1 SHALL latch in_char and dir_en; if in_char is 'a'..'z' or 'A'..'Z', the FSM SHALL go to DRIVE with its counter loaded to SETTLE_CYCLES.
REQ-021 In IDLE, in_valid=1 with a non-letter in_char SHALL go directly to OUT with out_char=in_char, without driving the cipher.
REQ-022 In DRIVE, letter_oh SHALL have exactly one bit set (the letter index, case-folded), cap SHALL be 1 for uppercase, and en SHALL equal the latched dir_en, all stable.
REQ-023 In DRIVE, the counter SHALL decrement each cycle; at 1, cipher_out SHALL be registered into out_char, letter_oh SHALL clear to 0 and the FSM SHALL go to OUT.
REQ-024 Letter latency SHALL be SETTLE_CYCLES+1 cycles from the accept edge to out_valid=1; non-letter latency SHALL be 1 cycle.
REQ-025 In OUT, out_char SHALL hold stable until out_ready=1, then the FSM SHALL return to IDLE; the next accept SHALL occur no earlier than the following cycle.
REQ-026 shift_oh SHALL always equal the one-hot encoding of the key register (bit key-1).
REQ-027 key_load with key_shift in 1..26 while in IDLE SHALL update the key register at that edge.
REQ-028 key_load with key_shift 0 or 27..31 SHALL leave the key register unchanged and set key_err; key_err SHALL clear only on rst.
REQ-029 key_load outside IDLE SHALL be ignored, with no key change and no error.
REQ-030 If key_load and in_valid coincide in IDLE, the new key SHALL take effect for the character accepted in that same cycle.
REQ-031 letter_oh and cap SHALL be 0 in every state except DRIVE.

Reset
REQ-032 rst=1 SHALL force the FSM to IDLE, the key register to 26, out_char to 8'h00, and out_valid, key_err, letter_oh, cap and en to 0.
REQ-033 rst=1 asserted mid-DRIVE or mid-OUT SHALL discard the character in flight, with no out_valid pulse following reset.

Verification
REQ-034 Load key 6; send 'a' with dir_en=0 while a cipher model returns 'g' -> letter_oh=bit0 and shift_oh=bit5; out_char='g' with out_valid 3 cycles after accept.
REQ-035 Send 'Z' with key 26 and a model returning 'Z' -> cap=1, letter_oh=bit25, shift_oh=bit25; out_char='Z'.
REQ-036 Send ' ' (8'h20) -> out_valid the next cycle with out_char=8'h20; letter_oh stays 0 throughout.
REQ-037 Load key_shift=0, then key_shift=27 -> key_err=1 and shift_oh remains unchanged; a subsequent legal load of 8 -> shift_oh=bit7 and key_err remains 1.
REQ-038 Hold out_ready=0 for 5 cycles in OUT -> out_char is stable and in_ready=0; assert rst during DRIVE -> all outputs match REQ-032 on the next cycle.
